// File: rtl/weight_pkg.sv
// Shared types and sizing for the weight buffer loader and its store.
package weight_pkg;

  localparam int unsigned MAX_LAYERS  = 2;
  localparam int unsigned MAX_FV      = 16;
  localparam int unsigned FV_W        = 16;
  localparam int unsigned MULT_PER_PE = 4;

  localparam int unsigned LAYER_W  = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam int unsigned FV_IDX_W = $clog2(MAX_FV);
  localparam int unsigned FV_CNT_W = FV_IDX_W + 1;
  localparam int unsigned BEAT_W   = MULT_PER_PE * FV_W;
  localparam int unsigned CKSUM_W  = FV_W + 8;

  typedef logic [MULT_PER_PE-1:0][FV_W-1:0] beat_t;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} loader_state_t;

  function automatic logic cfg_legal(logic [LAYER_W-1:0] num_layer,
                                     logic [FV_CNT_W-1:0] num_fv);
    return (num_fv != '0) &&
           (int'(num_fv) <= int'(MAX_FV)) &&
           ((int'(num_fv) % int'(MULT_PER_PE)) == 0) &&
           (int'(num_layer) < int'(MAX_LAYERS));
  endfunction

endpackage

// File: rtl/weight_store.sv
// Layer x feature-vector weight register array: beat write port, registered beat read port,
// synchronous clear on reset.
module weight_store
  import weight_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [LAYER_W-1:0]  wr_layer_i,
  input  logic [FV_CNT_W-1:0] wr_fv_i,
  input  beat_t               wr_data_i,
  input  logic                rd_en_i,
  input  logic [LAYER_W-1:0]  rd_layer_i,
  input  logic [FV_IDX_W-1:0] rd_fv_base_i,
  output logic                rd_valid_o,
  output beat_t               rd_data_o
);

  logic [FV_W-1:0] mem_q [MAX_LAYERS][MAX_FV];
  beat_t           rd_data_d, rd_data_q;
  logic            rd_valid_q;

  // Out-of-range words read as zero; the read samples the array before this cycle's write.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < int'(MULT_PER_PE); i++) begin
      if ((int'(rd_layer_i) < int'(MAX_LAYERS)) &&
          ((int'(rd_fv_base_i) + i) < int'(MAX_FV))) begin
        rd_data_d[i] = mem_q[rd_layer_i][FV_IDX_W'(int'(rd_fv_base_i) + i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < int'(MAX_LAYERS); l++) begin
        for (int f = 0; f < int'(MAX_FV); f++) begin
          mem_q[l][f] <= '0;
        end
      end
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      rd_data_q  <= rd_en_i ? rd_data_d : '0;
      if (wr_en_i) begin
        for (int i = 0; i < int'(MULT_PER_PE); i++) begin
          if ((int'(wr_layer_i) < int'(MAX_LAYERS)) &&
              ((int'(wr_fv_i) + i) < int'(MAX_FV))) begin
            mem_q[wr_layer_i][FV_IDX_W'(int'(wr_fv_i) + i)] <= wr_data_i[i];
          end
        end
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/weight_buffer_loader.sv
// Runtime loader filling the weight store from a valid/ready beat stream and serving read beats.
// Optional running checksum of loaded words enabled by WEIGHT_LOADER_CKSUM_EN.
module weight_buffer_loader
  import weight_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid_i,
  input  logic [LAYER_W-1:0]  cfg_num_layer_i,
  input  logic [FV_CNT_W-1:0] cfg_num_fv_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [BEAT_W-1:0]   in_data_i,
  output logic                load_busy_o,
  output logic                load_done_o,
  output logic                cfg_err_o,
  input  logic                rd_en_i,
  input  logic [LAYER_W-1:0]  rd_layer_i,
  input  logic [FV_IDX_W-1:0] rd_fv_base_i,
  output logic                rd_valid_o,
  output logic [BEAT_W-1:0]   rd_data_o
`ifdef WEIGHT_LOADER_CKSUM_EN
  ,
  output logic [CKSUM_W-1:0]  load_cksum_o
`endif
);

  loader_state_t       state_q, state_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic [FV_CNT_W-1:0] fv_q, fv_d;
  logic [LAYER_W-1:0]  num_layer_q, num_layer_d;
  logic [FV_CNT_W-1:0] num_fv_q, num_fv_d;
  logic                in_ready_q, in_ready_d;
  logic                cfg_err_q, cfg_err_d;

  logic                accept, fv_wrap, last_beat, cfg_ok;
  logic [FV_CNT_W-1:0] fv_inc;
  beat_t               wr_beat, rd_beat;

  assign wr_beat   = beat_t'(in_data_i);
  assign cfg_ok    = cfg_legal(cfg_num_layer_i, cfg_num_fv_i);
  assign accept    = (state_q == StLoad) && in_ready_q && in_valid_i;
  assign fv_inc    = fv_q + FV_CNT_W'(MULT_PER_PE);
  assign fv_wrap   = (fv_inc == num_fv_q);
  assign last_beat = accept && fv_wrap && (layer_q == num_layer_q);

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    fv_d        = fv_q;
    num_layer_d = num_layer_q;
    num_fv_d    = num_fv_q;
    in_ready_d  = in_ready_q;
    cfg_err_d   = cfg_err_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid_i) begin
          if (cfg_ok) begin
            state_d     = StLoad;
            num_layer_d = cfg_num_layer_i;
            num_fv_d    = cfg_num_fv_i;
            layer_d     = '0;
            fv_d        = '0;
            cfg_err_d   = 1'b0;
            in_ready_d  = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (last_beat) begin
          state_d    = StDone;
          in_ready_d = 1'b0;
          layer_d    = '0;
          fv_d       = '0;
        end else if (accept) begin
          if (fv_wrap) begin
            fv_d    = '0;
            layer_d = layer_q + LAYER_W'(1);
          end else begin
            fv_d = fv_inc;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        in_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      layer_q     <= '0;
      fv_q        <= '0;
      num_layer_q <= '0;
      num_fv_q    <= '0;
      in_ready_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      fv_q        <= fv_d;
      num_layer_q <= num_layer_d;
      num_fv_q    <= num_fv_d;
      in_ready_q  <= in_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

`ifdef WEIGHT_LOADER_CKSUM_EN
  logic [CKSUM_W-1:0] cksum_q, cksum_d, beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < int'(MULT_PER_PE); i++) begin
      beat_sum = beat_sum + CKSUM_W'(wr_beat[i]);
    end
    cksum_d = cksum_q;
    if ((state_q == StIdle) && cfg_valid_i && cfg_ok) begin
      cksum_d = '0;
    end else if (accept) begin
      cksum_d = cksum_q + beat_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign load_cksum_o = cksum_q;
`endif

  weight_store u_store (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (accept),
    .wr_layer_i   (layer_q),
    .wr_fv_i      (fv_q),
    .wr_data_i    (wr_beat),
    .rd_en_i      (rd_en_i),
    .rd_layer_i   (rd_layer_i),
    .rd_fv_base_i (rd_fv_base_i),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_beat)
  );

  assign rd_data_o   = rd_beat;
  assign in_ready_o  = in_ready_q;
  assign load_busy_o = (state_q == StLoad);
  assign load_done_o = (state_q == StDone);
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Self-checking bench for weight_buffer_loader: per-cycle reference model plus config table and
// directed corner sequences.
module tb_weight_buffer_loader;
  import weight_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_valid;
  logic [LAYER_W-1:0]  cfg_num_layer;
  logic [FV_CNT_W-1:0] cfg_num_fv;
  logic                in_valid;
  logic                in_ready;
  logic [BEAT_W-1:0]   in_data;
  logic                load_busy, load_done, cfg_err;
  logic                rd_en;
  logic [LAYER_W-1:0]  rd_layer;
  logic [FV_IDX_W-1:0] rd_fv_base;
  logic                rd_valid;
  logic [BEAT_W-1:0]   rd_data;
`ifdef WEIGHT_LOADER_CKSUM_EN
  logic [CKSUM_W-1:0]  load_cksum;
`endif

  always #5 clk = ~clk;

  weight_buffer_loader dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid_i     (cfg_valid),
    .cfg_num_layer_i (cfg_num_layer),
    .cfg_num_fv_i    (cfg_num_fv),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_data_i       (in_data),
    .load_busy_o     (load_busy),
    .load_done_o     (load_done),
    .cfg_err_o       (cfg_err),
    .rd_en_i         (rd_en),
    .rd_layer_i      (rd_layer),
    .rd_fv_base_i    (rd_fv_base),
    .rd_valid_o      (rd_valid),
    .rd_data_o       (rd_data)
`ifdef WEIGHT_LOADER_CKSUM_EN
    ,
    .load_cksum_o    (load_cksum)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 loading, 2 done pulse; k counts words loaded so far.
  logic [FV_W-1:0]    ref_mem [MAX_LAYERS][MAX_FV];
  int                 ph, k, m_nl, m_nfv;
  bit                 m_err;
  logic [CKSUM_W-1:0] m_cksum;

  task automatic chk(input string name, input logic [BEAT_W-1:0] act,
                     input logic [BEAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input int nl, input int nfv);
    return nfv != 0 && nfv <= int'(MAX_FV) && (nfv % int'(MULT_PER_PE)) == 0 &&
           nl < int'(MAX_LAYERS);
  endfunction

  function automatic logic [BEAT_W-1:0] model_read(input int layer, input int base);
    logic [BEAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MULT_PER_PE); i++) begin
      if (layer < int'(MAX_LAYERS) && base + i < int'(MAX_FV))
        r[i*FV_W +: FV_W] = ref_mem[layer][base+i];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < int'(MAX_LAYERS); l++)
      for (int f = 0; f < int'(MAX_FV); f++) ref_mem[l][f] = '0;
    ph = 0; k = 0; m_nl = 0; m_nfv = 0; m_err = 0; m_cksum = '0;
  endtask

  // One clock: model consumes the current inputs, then DUT outputs are compared.
  // cfg_valid and rd_en are one-shot and cleared afterwards.
  task automatic step();
    bit                rq;
    logic [BEAT_W-1:0] rexp;
    logic [FV_W-1:0]   w;
    int                ph_n, idx;
    rq   = rd_en;
    rexp = model_read(int'(rd_layer), int'(rd_fv_base));
    ph_n = ph;
    case (ph)
      0: if (cfg_valid) begin
        if (legal(int'(cfg_num_layer), int'(cfg_num_fv))) begin
          ph_n = 1; m_nl = int'(cfg_num_layer); m_nfv = int'(cfg_num_fv);
          k = 0; m_err = 0; m_cksum = '0;
        end else begin
          m_err = 1;
        end
      end
      1: if (in_valid) begin
        for (int i = 0; i < int'(MULT_PER_PE); i++) begin
          w   = in_data[i*FV_W +: FV_W];
          idx = k + i;
          ref_mem[idx / m_nfv][idx % m_nfv] = w;
          m_cksum = m_cksum + CKSUM_W'(w);
        end
        k += int'(MULT_PER_PE);
        if (k == (m_nl + 1) * m_nfv) ph_n = 2;
      end
      default: ph_n = 0;
    endcase
    ph = ph_n;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    rd_en     = 1'b0;
    chk("in_ready", BEAT_W'(in_ready), BEAT_W'(ph == 1));
    chk("load_busy", BEAT_W'(load_busy), BEAT_W'(ph == 1));
    chk("load_done", BEAT_W'(load_done), BEAT_W'(ph == 2));
    chk("cfg_err", BEAT_W'(cfg_err), BEAT_W'(m_err));
    chk("rd_valid", BEAT_W'(rd_valid), BEAT_W'(rq));
    if (rq) chk("rd_data", rd_data, rexp);
`ifdef WEIGHT_LOADER_CKSUM_EN
    if (ph == 2) chk("load_cksum", BEAT_W'(load_cksum), BEAT_W'(m_cksum));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1; cfg_valid = 0; in_valid = 0; rd_en = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_in_ready", BEAT_W'(in_ready), '0);
    chk("rst_busy", BEAT_W'(load_busy), '0);
    chk("rst_done", BEAT_W'(load_done), '0);
    chk("rst_cfg_err", BEAT_W'(cfg_err), '0);
    chk("rst_rd_valid", BEAT_W'(rd_valid), '0);
    reset = 1'b0;
  endtask

  task automatic start_cfg(input int nl, input int nfv);
    cfg_valid     = 1'b1;
    cfg_num_layer = LAYER_W'(nl);
    cfg_num_fv    = FV_CNT_W'(nfv);
    step();
  endtask

  // vmode: 0 valid held, 1 toggle 1,0,..., 2 random. dmode: 0 word=index, 1 random, 2 index+1.
  task automatic feed(input int nbeats, input int vmode, input int dmode, input bit rnd_rd);
    int got, budget, v;
    got = 0; budget = 0;
    while (got < nbeats && budget < 400) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (budget % 2) == 0;
        default: in_valid = 1'($urandom);
      endcase
      for (int i = 0; i < int'(MULT_PER_PE); i++) begin
        v = (dmode == 0) ? k + i : (dmode == 1) ? int'($urandom) : k + i + 1;
        in_data[i*FV_W +: FV_W] = FV_W'(v);
      end
      if (rnd_rd) begin
        rd_en      = 1'($urandom);
        rd_layer   = LAYER_W'($urandom);
        rd_fv_base = FV_IDX_W'($urandom);
        cfg_valid  = ($urandom_range(0, 7) == 0);
        cfg_num_fv = FV_CNT_W'($urandom_range(0, 20));
      end
      if (ph == 1 && in_valid) got++;
      step();
      budget++;
    end
    in_valid = 1'b0;
    chk("feed_beats", BEAT_W'(got), BEAT_W'(nbeats));
  endtask

  task automatic read_all();
    for (int l = 0; l < int'(MAX_LAYERS); l++) begin
      for (int b = 0; b < int'(MAX_FV); b += 2) begin
        rd_en = 1'b1; rd_layer = LAYER_W'(l); rd_fv_base = FV_IDX_W'(b);
        step();
      end
    end
  endtask

  typedef struct {
    int nl;
    int nfv;
    bit exp_err;
  } cfg_vec_t;

  cfg_vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 6, 1};
    vecs[1] = '{1, 20, 1};
    vecs[2] = '{0, 8, 0};
    vecs[3] = '{1, 0, 1};
    vecs[4] = '{1, 3, 1};
    vecs[5] = '{1, 4, 0};
    vecs[6] = '{1, 16, 0};
    vecs[7] = '{0, 12, 0};

    reset = 1'b1; cfg_valid = 0; cfg_num_layer = '0; cfg_num_fv = '0;
    in_valid = 0; in_data = '0; rd_en = 0; rd_layer = '0; rd_fv_base = '0;
    do_reset();

    // Legal load, valid held high
    start_cfg(1, 16);
    feed(8, 0, 0, 0);
    step();
    rd_en = 1'b1; rd_layer = 1; rd_fv_base = 4;
    step();
    chk("read_l1_fv4", rd_data, 64'h0017_0016_0015_0014);

    // Backpressure gaps, same contents expected
    start_cfg(1, 16);
    feed(8, 1, 0, 0);
    step();
    read_all();
    rd_en = 1'b1; rd_layer = 0; rd_fv_base = 12;
    step();
    chk("read_l0_fv12", rd_data, 64'h000f_000e_000d_000c);

    // Config table: illegal ones flag cfg_err, legal ones load random data
    for (int t = 0; t < 8; t++) begin
      start_cfg(vecs[t].nl, vecs[t].nfv);
      chk("tbl_cfg_err", BEAT_W'(cfg_err), BEAT_W'(vecs[t].exp_err));
      if (!vecs[t].exp_err) begin
        feed((vecs[t].nl + 1) * vecs[t].nfv / int'(MULT_PER_PE), 2, 1, 1);
        step();
        read_all();
      end
    end

    // Reset mid-load discards partial contents
    do_reset();
    start_cfg(1, 16);
    feed(3, 0, 1, 0);
    do_reset();
    read_all();
    rd_en = 1'b1; rd_layer = 0; rd_fv_base = 0;
    step();
    chk("post_rst_read", rd_data, '0);
    start_cfg(0, 8);
    feed(2, 2, 1, 1);
    step();
    read_all();

    // Read of a location in the same cycle its beat is written returns the old value
    do_reset();
    start_cfg(0, 4);
    in_valid = 1'b1; in_data = 64'h0008_0007_0006_0005;
    rd_en = 1'b1; rd_layer = 0; rd_fv_base = 0;
    step();
    chk("raw_old", rd_data, '0);
    in_valid = 1'b0; rd_en = 1'b1; rd_layer = 0; rd_fv_base = 0;
    step();
    chk("raw_new", rd_data, 64'h0008_0007_0006_0005);

`ifdef WEIGHT_LOADER_CKSUM_EN
    do_reset();
    start_cfg(1, 16);
    feed(8, 0, 2, 0);
    chk("cksum_528", BEAT_W'(load_cksum), BEAT_W'(528));
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_buffer_loader.md
Name: weight_buffer_loader

Overview:
- Writer-side counterpart of the weight controller: fills a layer x feature-vector weight store from an external valid/ready beat stream.
- Serves registered read beats (MULT_PER_PE words) to the weight controller.
- Replaces the hard-coded reset-time weight contents with a runtime load, one stream per inference configuration.

Parameters:
MAX_LAYERS, 2, weight layers held in the store
MAX_FV, 16, max feature-vector words per layer
FV_W, 16, bits per weight word
MULT_PER_PE, 4, words per load beat and per read beat

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cfg_valid  in  1  start-load strobe, sampled in IDLE only
cfg_num_layer  in  $clog2(MAX_LAYERS)  layers to load minus 1
cfg_num_fv  in  $clog2(MAX_FV)+1  words per layer
in_valid  in  1  load beat valid
in_ready  out  1  load beat accepted when in_valid&in_ready
in_data  in  MULT_PER_PE*FV_W  beat; word i in bits [i*FV_W +: FV_W]
load_busy  out  1  high in LOAD
load_done  out  1  one-cycle pulse after final beat accepted
cfg_err  out  1  sticky illegal-config flag, cleared by next legal cfg_valid
rd_en  in  1  read request
rd_layer  in  $clog2(MAX_LAYERS)  read layer
rd_fv_base  in  $clog2(MAX_FV)  first word of read beat
rd_valid  out  1  rd_data valid
rd_data  out  MULT_PER_PE*FV_W  read beat

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: all outputs 0; state IDLE; layer/fv counters 0; store cleared to 0; checksum 0.
- States: IDLE, LOAD, DONE.
- IDLE, cfg_valid, legal config -> LOAD:
  - latch cfg_num_layer/cfg_num_fv; counters 0; cfg_err cleared.
  - Legal config: cfg_num_fv != 0, cfg_num_fv <= MAX_FV, cfg_num_fv % MULT_PER_PE == 0, cfg_num_layer < MAX_LAYERS.
- IDLE, cfg_valid, illegal config: cfg_err <= 1, stay IDLE.
- LOAD:
  - in_ready = 1, registered; asserted from the cycle after entry.
  - Accepted beat writes store[layer][fv+i] = word i for i in 0..MULT_PER_PE-1, then fv += MULT_PER_PE.
  - fv == num_fv after increment: fv <= 0, layer += 1.
  - Final beat (layer == num_layer and fv wraps): in_ready <= 0 next cycle, -> DONE.
- DONE: load_done = 1 for exactly one cycle, then -> IDLE. The store is stable until the next load.
- Ignored inputs:
  - cfg_valid outside IDLE.
  - in_valid while in_ready = 0; in_data is not written.
- Read port:
  - Latency 1: rd_en in cycle N -> rd_valid and rd_data in cycle N+1.
  - rd_data word i = store[rd_layer][rd_fv_base+i].
  - Any index >= MAX_FV, or rd_layer >= MAX_LAYERS, returns word 0.
  - Reads are legal in any state. A read of a location written in the same cycle returns the old value (write-after-read).
  - rd_valid = 0 when no request.
- Reset mid-LOAD: immediate return to IDLE; partial contents discarded (cleared); no load_done.
- Arithmetic: fv counter $clog2(MAX_FV)+1 bits, so fv == MAX_FV is representable; no modulo wrap.

Optional Feature:
- Macro WEIGHT_LOADER_CKSUM_EN.
- Defined:
  - Extra output load_cksum, width FV_W+8.
  - Running unsigned sum of every accepted word; cleared on legal cfg_valid.
  - Final value valid from the load_done cycle until the next legal cfg_valid.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Shared package weight_pkg holds:
  - loader_state_t enum (IDLE, LOAD, DONE).
  - Localparams MAX_LAYERS, MAX_FV, FV_W, MULT_PER_PE, mirroring the global defines.
  - Beat type: packed array [MULT_PER_PE][FV_W].
- One sub-module, weight_store: the register array with beat write port, registered beat read port and clear-on-reset.
- FSM and counters stay in the top module.

Test Plan:
- Legal load: reset; cfg_num_layer=1, cfg_num_fv=16; 8 beats, word value = layer*16+index, in_valid held high.
  - Expect in_ready low during reset and IDLE, 8 accepts, load_done pulse one cycle after the 8th accept.
  - Then rd_layer=1, rd_fv_base=4 -> next cycle rd_data = {23,22,21,20}.
- Backpressure/gaps: same config, in_valid toggled 1,0,1,0.
  - Only valid cycles write; counters advance per accept.
  - load_done after exactly 8 accepts; final store identical to the first test.
- Illegal configs:
  - cfg_num_fv=6 -> cfg_err=1, state IDLE, in_ready=0.
  - cfg_num_fv=20 -> cfg_err=1.
  - Then legal cfg_num_fv=8 -> cfg_err=0, load proceeds.
- Reset mid-load: reset asserted after 3 of 8 beats.
  - Expect IDLE, no load_done, all reads return 0.
  - A new cfg_valid starts a fresh load.
- Read during write: rd_en for address [0][0..3] in the same cycle its first beat {5,6,7,8} is accepted.
  - rd_data = 0 next cycle; repeat read -> {8,7,6,5}.
- With WEIGHT_LOADER_CKSUM_EN: load words 1..32 (2 layers x 16 words) -> load_cksum = 528 at load_done.
